// File: rtl/vm1_qirq_chain_pkg.sv
// Shared definitions for the Q-bus vectored-interrupt chain controller:
// handshake state codes and bus signal levels.
package vm1_qirq_chain_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACKD  = 2'd1,
        ST_REPLY = 2'd2,
        ST_PASS  = 2'd3
    } qirq_state_t;

    localparam logic BUS_ASSERT  = 1'b0;
    localparam logic BUS_RELEASE = 1'b1;

endpackage

// File: rtl/vm1_qirq_chain_sync2.sv
// Two-flop synchroniser for asynchronous bus strobes.
// Resets to the released level so no false strobe follows reset.
module vm1_qirq_chain_sync2 #(
    parameter int            W    = 1,
    parameter logic [W-1:0]  INIT = '1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] meta;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= INIT;
            q    <= INIT;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/vm1_qirq_chain.sv
// Q-bus vectored-interrupt controller: NCH request channels, one bus
// request, IAKI/IAKO daisy chain and vector read-out on the IACK DIN cycle.
module vm1_qirq_chain
    import vm1_qirq_chain_pkg::*;
#(
    parameter int             NCH  = 4,
    parameter int             RR   = 0,
    parameter logic [NCH-1:0] EDGE = '0,
    parameter int             VW   = 16
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [NCH-1:0]    REQ,
    input  logic [NCH*VW-1:0] VEC,
    output logic [NCH-1:0]    ACK,
    input  logic              nIAKI,
    input  logic              nDIN,
    input  logic              nSYNC,
    output logic              nVIRQ,
    output logic              nIAKO,
    output logic              nRPLY,
    output logic [VW-1:0]     DAT,
    output logic              DAT_OE
);

    localparam int PW = (NCH > 1) ? $clog2(NCH) : 1;

    logic iaki_s, din_s, sync_s, iack;

    vm1_qirq_chain_sync2 #(.W(1), .INIT(1'b1)) u_sync_iaki (
        .clk(CLK), .rst(RST), .d(nIAKI), .q(iaki_s)
    );
    vm1_qirq_chain_sync2 #(.W(1), .INIT(1'b1)) u_sync_din (
        .clk(CLK), .rst(RST), .d(nDIN), .q(din_s)
    );
    vm1_qirq_chain_sync2 #(.W(1), .INIT(1'b1)) u_sync_sync (
        .clk(CLK), .rst(RST), .d(nSYNC), .q(sync_s)
    );

    // First set request at or after base, wrapping at NCH-1.
    function automatic logic [PW-1:0] pick(
        input logic [NCH-1:0] p,
        input logic [PW-1:0]  base
    );
        logic found;
        int   idx;
        pick  = '0;
        found = 1'b0;
        for (int k = 0; k < NCH; k++) begin
            idx = (int'(base) + k) % NCH;
            if (!found && p[idx]) begin
                pick  = PW'(idx);
                found = 1'b1;
            end
        end
    endfunction

    qirq_state_t    state, state_nx;
    logic [PW-1:0]  w, w_nx, rr_ptr, rr_nx, win;
    logic [NCH-1:0] req_q, pend_e, pend, rise, ack_nx;
    logic [VW-1:0]  dat_nx;
    logic           oe_nx, rply_nx, iako_nx, virq_nx;

    // A served edge channel is masked during its ACK cycle; a new edge
    // in that same cycle still re-arms it.
    assign rise = REQ & ~req_q;
    assign pend = (EDGE & pend_e & ~ACK) | (~EDGE & REQ);
    assign iack = ~iaki_s & ~din_s & sync_s;
    assign win  = pick(pend, (RR != 0) ? rr_ptr : PW'(0));

    always_comb begin
        state_nx = state;
        w_nx     = w;
        rr_nx    = rr_ptr;
        dat_nx   = DAT;
        oe_nx    = DAT_OE;
        rply_nx  = nRPLY;
        iako_nx  = nIAKO;
        ack_nx   = '0;
        unique case (state)
            ST_IDLE: begin
                if (iack) begin
                    if (|pend) begin
                        w_nx     = win;
                        dat_nx   = VEC[int'(win)*VW +: VW];
                        oe_nx    = 1'b1;
                        state_nx = ST_ACKD;
                    end else begin
                        state_nx = ST_PASS;
                    end
                end
            end
            ST_ACKD: begin
                rply_nx  = BUS_ASSERT;
                state_nx = ST_REPLY;
            end
            ST_REPLY: begin
                if (din_s) begin
                    rply_nx   = BUS_RELEASE;
                    oe_nx     = 1'b0;
                    dat_nx    = '0;
                    ack_nx[w] = 1'b1;
                    if (RR != 0)
                        rr_nx = (w == PW'(NCH-1)) ? PW'(0) : w + PW'(1);
                    state_nx  = ST_IDLE;
                end
            end
            ST_PASS: begin
                if (iaki_s) begin
                    iako_nx  = BUS_RELEASE;
                    state_nx = ST_IDLE;
                end else begin
                    iako_nx  = BUS_ASSERT;
                end
            end
            default: state_nx = ST_IDLE;
        endcase
        virq_nx = ~|(pend & ~ack_nx)
                | (state_nx == ST_ACKD)
                | (state_nx == ST_REPLY);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state  <= ST_IDLE;
            w      <= '0;
            rr_ptr <= '0;
            req_q  <= REQ;
            pend_e <= '0;
            DAT    <= '0;
            DAT_OE <= 1'b0;
            nRPLY  <= BUS_RELEASE;
            nIAKO  <= BUS_RELEASE;
            nVIRQ  <= BUS_RELEASE;
            ACK    <= '0;
        end else begin
            state  <= state_nx;
            w      <= w_nx;
            rr_ptr <= rr_nx;
            req_q  <= REQ;
            pend_e <= EDGE & ((pend_e & ~ACK) | rise);
            DAT    <= dat_nx;
            DAT_OE <= oe_nx;
            nRPLY  <= rply_nx;
            nIAKO  <= iako_nx;
            nVIRQ  <= virq_nx;
            ACK    <= ack_nx;
        end
    end

endmodule

// File: tb/tb_vm1_qirq_chain.sv
// Bench for vm1_qirq_chain: fixed, round-robin and edge-mode instances
// share one bus; a priority model predicts each acknowledge cycle.
module tb_vm1_qirq_chain;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic [3:0]  REQ = 4'b0000;
    logic [63:0] VEC;
    logic        nIAKI = 1'b1;
    logic        nDIN  = 1'b1;
    logic        nSYNC = 1'b1;

    logic [3:0]  ack_o  [3];
    logic        virq_o [3];
    logic        iako_o [3];
    logic        rply_o [3];
    logic        oe_o   [3];
    logic [15:0] dat_o  [3];

    logic [15:0] vec_tbl [4];

    vm1_qirq_chain #(.NCH(4), .RR(0), .EDGE(4'b0000), .VW(16)) u_fix (
        .CLK(CLK), .RST(RST), .REQ(REQ), .VEC(VEC), .ACK(ack_o[0]),
        .nIAKI(nIAKI), .nDIN(nDIN), .nSYNC(nSYNC), .nVIRQ(virq_o[0]),
        .nIAKO(iako_o[0]), .nRPLY(rply_o[0]), .DAT(dat_o[0]),
        .DAT_OE(oe_o[0])
    );
    vm1_qirq_chain #(.NCH(4), .RR(1), .EDGE(4'b0000), .VW(16)) u_rr (
        .CLK(CLK), .RST(RST), .REQ(REQ), .VEC(VEC), .ACK(ack_o[1]),
        .nIAKI(nIAKI), .nDIN(nDIN), .nSYNC(nSYNC), .nVIRQ(virq_o[1]),
        .nIAKO(iako_o[1]), .nRPLY(rply_o[1]), .DAT(dat_o[1]),
        .DAT_OE(oe_o[1])
    );
    vm1_qirq_chain #(.NCH(4), .RR(0), .EDGE(4'b0001), .VW(16)) u_edg (
        .CLK(CLK), .RST(RST), .REQ(REQ), .VEC(VEC), .ACK(ack_o[2]),
        .nIAKI(nIAKI), .nDIN(nDIN), .nSYNC(nSYNC), .nVIRQ(virq_o[2]),
        .nIAKO(iako_o[2]), .nRPLY(rply_o[2]), .DAT(dat_o[2]),
        .DAT_OE(oe_o[2])
    );

    always #5 CLK = ~CLK;

    int vectors     = 0;
    int miscompares = 0;
    int rr_m        = 0;

    logic [15:0] r_dat  [3];
    logic [3:0]  r_ack  [3];
    logic [18:0] r_end  [3];
    int          r_rply [3];
    int          r_oe   [3];
    int          r_iako [3];

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic sample(input int c);
        for (int i = 0; i < 3; i++) begin
            if (oe_o[i] && r_oe[i] < 0) r_oe[i] = c;
            if (!rply_o[i] && r_rply[i] < 0) begin
                r_rply[i] = c;
                r_dat[i]  = dat_o[i];
            end
            if (!iako_o[i] && r_iako[i] < 0) r_iako[i] = c;
            r_ack[i] = r_ack[i] | ack_o[i];
        end
    endtask

    // One full interrupt-acknowledge bus cycle; rearm raises REQ[0]
    // in the cycle where the edge instance pulses ACK.
    task automatic iack(input bit rearm);
        for (int i = 0; i < 3; i++) begin
            r_dat[i]  = '0;
            r_ack[i]  = '0;
            r_rply[i] = -1;
            r_oe[i]   = -1;
            r_iako[i] = -1;
        end
        nSYNC = 1'b1;
        nIAKI = 1'b0;
        nDIN  = 1'b0;
        for (int c = 0; c < 7; c++) begin
            tick();
            sample(c);
        end
        nDIN  = 1'b1;
        nIAKI = 1'b1;
        for (int c = 7; c < 14; c++) begin
            tick();
            sample(c);
            if (rearm && ack_o[2][0]) REQ[0] = 1'b1;
        end
        for (int i = 0; i < 3; i++)
            r_end[i] = {rply_o[i], oe_o[i], iako_o[i], dat_o[i]};
    endtask

    task automatic expect_reply(input string tag, input int i,
                                input int ch);
        chk({tag, "_dat"}, 32'(r_dat[i]), 32'(vec_tbl[ch]));
        chk({tag, "_ack"}, 32'(r_ack[i]), 32'(1) << ch);
        chk({tag, "_oe_lead"}, 32'(r_rply[i] - r_oe[i]), 32'(1));
        chk({tag, "_no_iako"}, 32'(r_iako[i]), 32'(-1));
        chk({tag, "_end"}, 32'(r_end[i]), 32'({3'b101, 16'h0}));
    endtask

    task automatic expect_pass(input string tag, input int i);
        chk({tag, "_no_rply"}, 32'(r_rply[i]), 32'(-1));
        chk({tag, "_iako_at"}, 32'(r_iako[i]), 32'(3));
        chk({tag, "_ack"}, 32'(r_ack[i]), 32'(0));
        chk({tag, "_end"}, 32'(r_end[i]), 32'({3'b101, 16'h0}));
    endtask

    function automatic int lowest(input logic [3:0] r);
        for (int k = 0; k < 4; k++)
            if (r[k]) return k;
        return -1;
    endfunction

    function automatic int rr_pick(input logic [3:0] r, input int p);
        for (int k = 0; k < 4; k++)
            if (r[(p + k) % 4]) return (p + k) % 4;
        return -1;
    endfunction

    // Level request pattern on the fixed and round-robin instances.
    task automatic serve(input string tag, input logic [3:0] r);
        int ef;
        int er;
        REQ = r;
        repeat (3) tick();
        chk({tag, "_virq_fix"}, 32'(virq_o[0]), 32'(r == 4'b0));
        chk({tag, "_virq_rr"}, 32'(virq_o[1]), 32'(r == 4'b0));
        iack(1'b0);
        ef = lowest(r);
        er = rr_pick(r, rr_m);
        if (ef < 0) begin
            expect_pass({tag, "_fix"}, 0);
            expect_pass({tag, "_rr"}, 1);
        end else begin
            expect_reply({tag, "_fix"}, 0, ef);
            expect_reply({tag, "_rr"}, 1, er);
            rr_m = (er + 1) % 4;
        end
    endtask

    task automatic do_reset();
        RST = 1'b1;
        repeat (2) tick();
        RST  = 1'b0;
        rr_m = 0;
        tick();
    endtask

    initial begin
        int   k;
        logic [3:0] acc;
        vec_tbl[0] = 16'o060;
        vec_tbl[1] = 16'o064;
        vec_tbl[2] = 16'o070;
        vec_tbl[3] = 16'o074;
        VEC = {vec_tbl[3], vec_tbl[2], vec_tbl[1], vec_tbl[0]};

        RST = 1'b1;
        repeat (2) tick();
        for (int i = 0; i < 3; i++)
            chk("reset_outs",
                32'({virq_o[i], iako_o[i], rply_o[i], oe_o[i],
                     ack_o[i], dat_o[i]}),
                32'({4'b1110, 4'b0000, 16'h0}));
        RST = 1'b0;
        tick();

        REQ = 4'b0100;
        repeat (2) tick();
        chk("lvl_virq", 32'(virq_o[0]), 32'(0));
        iack(1'b0);
        chk("lvl_dat070", 32'(r_dat[0]), 32'(16'o070));
        chk("lvl_ack", 32'(r_ack[0]), 32'(4'b0100));
        expect_reply("lvl", 0, 2);
        rr_m = 3;

        REQ = 4'b0000;
        repeat (3) tick();
        chk("idle_virq", 32'(virq_o[0]), 32'(1));

        do_reset();
        REQ = 4'b1010;
        repeat (3) tick();
        iack(1'b0);
        chk("fix_first064", 32'(r_dat[0]), 32'(16'o064));
        chk("rr_seq0_064", 32'(r_dat[1]), 32'(16'o064));
        iack(1'b0);
        chk("fix_again064", 32'(r_dat[0]), 32'(16'o064));
        chk("rr_seq1_074", 32'(r_dat[1]), 32'(16'o074));
        iack(1'b0);
        chk("rr_seq2_064", 32'(r_dat[1]), 32'(16'o064));
        chk("rr_seq2_ack", 32'(r_ack[1]), 32'(4'b0010));
        rr_m = 2;

        REQ = 4'b0100;
        repeat (3) tick();
        chk("drop_virq_on", 32'(virq_o[0]), 32'(0));
        REQ = 4'b0000;
        repeat (2) tick();
        chk("drop_virq_off", 32'(virq_o[0]), 32'(1));
        iack(1'b0);
        expect_pass("drop_pass", 0);

        REQ = 4'b0001;
        tick();
        REQ = 4'b0000;
        repeat (3) tick();
        chk("edge_held", 32'(virq_o[2]), 32'(0));
        chk("edge_lvl_gone", 32'(virq_o[0]), 32'(1));
        iack(1'b1);
        expect_reply("edge1", 2, 0);
        expect_pass("edge1_fix", 0);
        repeat (3) tick();
        chk("edge_repend", 32'(virq_o[2]), 32'(0));
        REQ = 4'b0000;
        iack(1'b0);
        expect_reply("edge2", 2, 0);
        repeat (3) tick();
        chk("edge_cleared", 32'(virq_o[2]), 32'(1));

        REQ = 4'b0001;
        tick();
        REQ = 4'b0000;
        repeat (2) tick();
        nSYNC = 1'b1;
        nIAKI = 1'b0;
        nDIN  = 1'b0;
        k = 0;
        while (rply_o[2] !== 1'b0 && k < 10) begin
            tick();
            k++;
        end
        chk("rst_reached_reply", 32'(rply_o[2]), 32'(0));
        RST   = 1'b1;
        nIAKI = 1'b1;
        nDIN  = 1'b1;
        tick();
        chk("rst_mid_outs",
            32'({virq_o[2], iako_o[2], rply_o[2], oe_o[2],
                 ack_o[2], dat_o[2]}),
            32'({4'b1110, 4'b0000, 16'h0}));
        RST  = 1'b0;
        rr_m = 0;
        acc  = '0;
        for (int c = 0; c < 6; c++) begin
            tick();
            acc = acc | ack_o[2];
        end
        chk("rst_no_ack", 32'(acc), 32'(0));
        chk("rst_pend_clr", 32'(virq_o[2]), 32'(1));

        for (int n = 0; n < 24; n++)
            serve("rand", 4'($urandom_range(0, 15)));

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
